// File: rtl/multi_timer_if.sv
// Register port bundle for multi_timer.
// The slave acks one cycle after req and returns rdata with that ack.
interface multi_timer_if #(
  parameter int XLEN      = 32,
  parameter int AddrWidth = 6
);
  logic                 req;
  logic                 we;
  logic [AddrWidth-1:0] addr;
  logic [XLEN-1:0]      wdata;
  logic [XLEN-1:0]      rdata;
  logic                 ack;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/multi_timer.sv
// Machine timer: prescaled free-running counter with NumCmp
// one-shot/periodic compare channels, sticky pending and irq enables.
module multi_timer #(
  parameter int CountWidth    = 64,
  parameter int XLEN          = 32,
  parameter int NumCmp        = 4,
  parameter int PrescaleWidth = 16,
  parameter int AddrWidth     = 6
) (
  input  logic              clk,
  input  logic              rst,
  multi_timer_if.slave      bus,
  input  logic              debug,
  output logic [NumCmp-1:0] irq,
  output logic              irq_any
);

  localparam int EW = 2 * XLEN;
  typedef logic [CountWidth-1:0] cnt_t;

  cnt_t                     time_q, time_d;
  logic [EW-1:0]            time_ext;
  logic [PrescaleWidth-1:0] pcnt_q, pcnt_d, pre_q;
  logic                     en_q, sid_q;
  logic [NumCmp-1:0]        pend_q, pend_d, ena_q, prd_q;
  logic [NumCmp-1:0]        match, w1c;
  cnt_t                     cmp_q [NumCmp];
  cnt_t                     cmp_d [NumCmp];
  logic [XLEN-1:0]          per_q [NumCmp];
  logic [XLEN-1:0]          rd_val;
  logic [AddrWidth-1:0]     a;
  logic [5:0]               sys_sel, sys_wr;
  logic                     wr, run, tick;

  function automatic logic [AddrWidth-1:0] ch_addr(int ch, int k);
    return AddrWidth'(8 + 4 * ch + k);
  endfunction

  assign a        = bus.addr;
  assign wr       = bus.req && bus.we;
  assign sys_sel  = (a < AddrWidth'(8)) ? 6'(1) << a[2:0] : 6'h0;
  assign sys_wr   = wr ? sys_sel : 6'h0;
  assign time_ext = EW'(time_q);
  assign run      = en_q && !(debug && sid_q);
  assign tick     = run && (pcnt_q == '0);
  assign irq      = pend_q & ena_q;
  assign irq_any  = |irq;

  // Software writes to either time half suppress the tick.
  always_comb begin
    logic [EW-1:0] t;
    t      = time_ext;
    time_d = time_q;
    if (sys_wr[0]) begin
      t[XLEN-1:0] = bus.wdata;
      time_d      = cnt_t'(t);
    end else if (sys_wr[1]) begin
      t[EW-1:XLEN] = bus.wdata;
      time_d       = cnt_t'(t);
    end else if (tick) begin
      time_d = time_q + cnt_t'(1);
    end
  end

  always_comb begin
    pcnt_d = pcnt_q;
    if (sys_wr[2])
      pcnt_d = bus.wdata[PrescaleWidth-1:0];
    else if (run)
      pcnt_d = (pcnt_q == '0) ? pre_q
                              : pcnt_q - PrescaleWidth'(1);
  end

  // Reload first, then let a software write override its half.
  always_comb begin
    logic [EW-1:0] c;
    match = '0;
    for (int i = 0; i < NumCmp; i++) begin
      match[i] = time_q >= cmp_q[i];
      c = EW'(cmp_q[i]);
      if (match[i] && prd_q[i])
        c = EW'(cmp_q[i] + cnt_t'(per_q[i]));
      if (wr && a == ch_addr(i, 0))
        c[XLEN-1:0] = bus.wdata;
      if (wr && a == ch_addr(i, 1))
        c[EW-1:XLEN] = bus.wdata;
      cmp_d[i] = cnt_t'(c);
    end
    w1c    = sys_wr[4] ? bus.wdata[NumCmp-1:0] : '0;
    pend_d = (pend_q & ~w1c) | match;
  end

  always_comb begin
    logic [EW-1:0] ce;
    rd_val = '0;
    unique case (1'b1)
      sys_sel[0]: rd_val = time_ext[XLEN-1:0];
      sys_sel[1]: rd_val = time_ext[EW-1:XLEN];
      sys_sel[2]: rd_val = XLEN'(pre_q);
      sys_sel[3]: rd_val = XLEN'({sid_q, en_q});
      sys_sel[4]: rd_val = XLEN'(pend_q);
      sys_sel[5]: rd_val = XLEN'(ena_q);
      default: ;
    endcase
    for (int i = 0; i < NumCmp; i++) begin
      ce = EW'(cmp_q[i]);
      if (a == ch_addr(i, 0)) rd_val = ce[XLEN-1:0];
      if (a == ch_addr(i, 1)) rd_val = ce[EW-1:XLEN];
      if (a == ch_addr(i, 2)) rd_val = per_q[i];
      if (a == ch_addr(i, 3)) rd_val = XLEN'(prd_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q    <= '0;
      pcnt_q    <= '0;
      pre_q     <= '0;
      en_q      <= 1'b1;
      sid_q     <= 1'b0;
      pend_q    <= '0;
      ena_q     <= '0;
      prd_q     <= '0;
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      for (int i = 0; i < NumCmp; i++) begin
        cmp_q[i] <= '1;
        per_q[i] <= '0;
      end
    end else begin
      time_q    <= time_d;
      pcnt_q    <= pcnt_d;
      pend_q    <= pend_d;
      bus.ack   <= bus.req;
      bus.rdata <= (bus.req && !bus.we) ? rd_val : '0;
      if (sys_wr[2]) pre_q <= bus.wdata[PrescaleWidth-1:0];
      if (sys_wr[3]) begin
        en_q  <= bus.wdata[0];
        sid_q <= bus.wdata[1];
      end
      if (sys_wr[5]) ena_q <= bus.wdata[NumCmp-1:0];
      for (int i = 0; i < NumCmp; i++) begin
        cmp_q[i] <= cmp_d[i];
        if (wr && a == ch_addr(i, 2)) per_q[i] <= bus.wdata;
        if (wr && a == ch_addr(i, 3)) prd_q[i] <= bus.wdata[0];
      end
    end
  end

endmodule
